// File: rtl/fb_scanout.sv
// fb_scanout: read-side scan-out engine for the 240x160 framebuffer.
// One source line is prefetched per display-line pair into a ping-pong line
// buffer during the right-hand horizontal tail. The window is then shown at
// 2x horizontal and 2x vertical replication from the front buffer.
module fb_scanout #(
  parameter int SRC_W   = 240,
  parameter int SRC_H   = 160,
  parameter int X_START = 80,
  parameter int Y_START = 80,
  parameter int FETCH_X = 560,
  parameter int V_TOTAL = 525
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DRAWX,
  input  logic [9:0]  DRAWY,
  output logic [18:0] fb_read_address,
  input  logic [23:0] fb_data,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        line_valid,
  output logic        underflow
);

  localparam logic [9:0]  X_LO       = 10'(X_START);
  localparam logic [9:0]  X_HI       = 10'(X_START + 2 * SRC_W);
  localparam logic [9:0]  Y_LO       = 10'(Y_START);
  localparam logic [9:0]  Y_HI       = 10'(Y_START + 2 * SRC_H);
  localparam logic [9:0]  FETCH_COL  = 10'(FETCH_X);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [7:0]  LAST_COL   = 8'(SRC_W - 1);
  localparam logic [18:0] LINE_WORDS = 19'(SRC_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Registered state
  fetch_state_e state_q, state_d;
  logic [7:0]   col_q, col_d;         // next source column to issue
  logic [18:0]  base_q, base_d;       // s*SRC_W of the line being fetched
  logic         tgt_q, tgt_d;         // buffer the fetch writes into
  logic         wr_en_q, wr_en_d;     // write pipeline: data arrives 1 Clk late
  logic [7:0]   wr_col_q, wr_col_d;
  logic [1:0]   valid_q, valid_d;     // one "holds a fetched line" flag per buffer
  logic         front_sel_q, front_sel_d;
  logic         line_valid_q, line_valid_d;
  logic         underflow_q, underflow_d;
  logic [23:0]  rgb_q, rgb_d;

  // Ping-pong line storage, indexed [buffer][column]
  logic [23:0]  line_buf [2][SRC_W];

  // Decoded position information
  logic [9:0]   y_next;
  logic [9:0]   rel_next;
  logic [9:0]   rel_cur;
  logic         fetch_row;
  logic         pair_row;
  logic         trigger;
  logic         start;
  logic         swap_row;
  logic         disp_en;
  logic [7:0]   src_row;
  logic [7:0]   pix_col;
  logic [18:0]  fetch_base;
  logic [1:0]   valid_eff;

  // Decode fetch trigger, pair-start swap point and display window from the raster position
  always_comb begin
    y_next     = (DRAWY == V_LAST) ? '0 : DRAWY + 10'd1;
    rel_next   = y_next - Y_LO;
    rel_cur    = DRAWY - Y_LO;
    fetch_row  = (y_next >= Y_LO) && (y_next < Y_HI) && !rel_next[0];
    pair_row   = (DRAWY >= Y_LO) && (DRAWY < Y_HI) && !rel_cur[0];
    trigger    = (DRAWX == FETCH_COL) && fetch_row;
    start      = trigger && (state_q != ST_FETCH);
    swap_row   = (DRAWX == '0) && pair_row;
    src_row    = 8'(rel_next >> 1);
    fetch_base = 19'(src_row) * LINE_WORDS;
    disp_en    = line_valid_q && (DRAWX >= X_LO) && (DRAWX < X_HI) &&
                 (DRAWY >= Y_LO) && (DRAWY < Y_HI);
    pix_col    = 8'((DRAWX - X_LO) >> 1);
  end

  // State register and all control/pipeline flops
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      base_q       <= '0;
      tgt_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_col_q     <= '0;
      valid_q      <= '0;
      front_sel_q  <= 1'b0;
      line_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
      rgb_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      state_q      <= state_d;
      col_q        <= col_d;
      base_q       <= base_d;
      tgt_q        <= tgt_d;
      wr_en_q      <= wr_en_d;
      wr_col_q     <= wr_col_d;
      valid_q      <= valid_d;
      front_sel_q  <= front_sel_d;
      line_valid_q <= line_valid_d;
      underflow_q  <= underflow_d;
      rgb_q        <= rgb_d;
    end
  end

  // Fetch FSM next-state: issue SRC_W addresses, then one drain cycle for the last write
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (trigger) state_d = ST_FETCH;
      ST_FETCH: if (col_q == LAST_COL) state_d = ST_DRAIN;
      ST_DRAIN: state_d = trigger ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Fetch datapath outputs: read address and the delayed write request
  always_comb begin
    fb_read_address = '0;
    col_d           = col_q;
    base_d          = base_q;
    tgt_d           = tgt_q;
    wr_en_d         = 1'b0;
    wr_col_d        = wr_col_q;
    if (start) begin
      // First address goes out in the trigger cycle itself
      fb_read_address = fetch_base;
      col_d           = 8'd1;
      base_d          = fetch_base;
      tgt_d           = ~front_sel_d;
      wr_en_d         = 1'b1;
      wr_col_d        = '0;
    end else if (state_q == ST_FETCH) begin
      fb_read_address = base_q + 19'(col_q);
      col_d           = col_q + 8'd1;
      wr_en_d         = 1'b1;
      wr_col_d        = col_q;
    end
  end

  // Swap and valid bookkeeping; the drain's valid-set is visible to a same-cycle swap
  always_comb begin
    valid_eff = valid_q;
    if (state_q == ST_DRAIN) valid_eff[tgt_q] = 1'b1;

    valid_d      = valid_eff;
    front_sel_d  = front_sel_q;
    line_valid_d = line_valid_q;
    underflow_d  = underflow_q;
    if (swap_row) begin
      if (valid_eff[~front_sel_q]) begin
        front_sel_d           = ~front_sel_q;
        line_valid_d          = 1'b1;
        // The old front becomes the back and no longer counts as a fresh line
        valid_d[front_sel_q]  = 1'b0;
      end else begin
        underflow_d  = 1'b1;
        line_valid_d = 1'b0;
      end
    end
    // A new fetch invalidates whatever the (possibly just-swapped) back buffer held
    if (start) valid_d[~front_sel_d] = 1'b0;
  end

  // Pixel select: front buffer column with 2x horizontal replication, black outside
  always_comb begin
    rgb_d = '0;
    if (disp_en) rgb_d = line_buf[front_sel_q][pix_col];
  end

  // Line buffer write port, one Clk behind the address that produced the data
  always_ff @(posedge Clk) begin
    // NOTE: storage arrays carry no reset; the valid flags say whether contents matter.
    if (wr_en_q) line_buf[tgt_q][wr_col_q] <= fb_data;
  end

  assign R          = rgb_q[23:16];
  assign G          = rgb_q[15:8];
  assign B          = rgb_q[7:0];
  assign line_valid = line_valid_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: drives raster positions for selected rows, models the
// framebuffer RAM (1-Clk read latency) and compares every cycle against a
// line-level reference model of prefetch, swap and replicated display.
module tb_fb_scanout;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DRAWX;
  logic [9:0]  DRAWY;
  logic [18:0] fb_read_address;
  logic [23:0] fb_data = '0;
  logic [7:0]  R, G, B;
  logic        line_valid;
  logic        underflow;

  fb_scanout dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .DRAWX           (DRAWX),
    .DRAWY           (DRAWY),
    .fb_read_address (fb_read_address),
    .fb_data         (fb_data),
    .R               (R),
    .G               (G),
    .B               (B),
    .line_valid      (line_valid),
    .underflow       (underflow)
  );

  always #5 Clk = ~Clk;

  // Framebuffer RAM model: data valid 1 Clk after the address
  logic [23:0] fb_mem [0:38399];
  always @(posedge Clk) fb_data <= fb_mem[fb_read_address];

  int n_checks = 0;
  int n_errors = 0;
  int cur_x = 0;
  int cur_y = 0;

  // Reference model state
  logic [23:0] m_front [0:239];
  logic [23:0] m_pend  [0:239];
  bit          m_pend_ok;
  bit          m_lv;
  bit          m_uf;
  logic [23:0] m_rgb;
  int          m_fetch_k;
  int          m_fetch_base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at x=%0d y=%0d: got %0h expected %0h", tag, cur_x, cur_y, got, exp);
    end
  endtask

  function automatic bit pair_start(input int y);
    return (y >= 80) && (y < 400) && (((y - 80) % 2) == 0);
  endfunction

  task automatic model_reset();
    m_pend_ok = 0;
    m_lv      = 0;
    m_uf      = 0;
    m_rgb     = '0;
    m_fetch_k = -1;
  endtask

  task automatic mutate_row(input int s);
    for (int c = 0; c < 240; c++) fb_mem[s * 240 + c] = 24'($urandom);
  endtask

  // One pixel clock at raster position (x,y)
  task automatic step(input int x, input int y);
    int exp_addr;
    int yn;
    @(negedge Clk);
    check("rgb", {8'h0, R, G, B}, {8'h0, m_rgb});
    check("line_valid", {31'h0, line_valid}, {31'h0, m_lv});
    check("underflow", {31'h0, underflow}, {31'h0, m_uf});
    DRAWX = 10'(x);
    DRAWY = 10'(y);
    cur_x = x;
    cur_y = y;
    // Pair start: consume the prefetched line or flag underflow
    if (x == 0 && pair_start(y)) begin
      if (m_pend_ok) begin
        for (int c = 0; c < 240; c++) m_front[c] = m_pend[c];
        m_lv      = 1;
        m_pend_ok = 0;
      end else begin
        m_uf = 1;
        m_lv = 0;
      end
    end
    // Address stream: 240 consecutive words from the trigger cycle
    exp_addr = 0;
    if (m_fetch_k >= 0 && m_fetch_k < 240) begin
      exp_addr = m_fetch_base + m_fetch_k;
      m_fetch_k++;
    end else begin
      m_fetch_k = -1;
    end
    yn = (y == 524) ? 0 : y + 1;
    if (x == 560 && pair_start(yn)) begin
      m_fetch_base = ((yn - 80) / 2) * 240;
      exp_addr     = m_fetch_base;
      m_fetch_k    = 1;
      for (int c = 0; c < 240; c++) m_pend[c] = fb_mem[m_fetch_base + c];
      m_pend_ok = 1;
    end
    #1;
    check("addr", {13'h0, fb_read_address}, exp_addr);
    if (x >= 80 && x < 560 && y >= 80 && y < 400 && m_lv)
      m_rgb = m_front[(x - 80) / 2];
    else
      m_rgb = '0;
  endtask

  task automatic run_row(input int y, input int mut_row = -1);
    for (int x = 0; x < 800; x++) begin
      if (x == 100 && mut_row >= 0) mutate_row(mut_row);
      step(x, y);
    end
  endtask

  // Hold Reset low for n cycles at the current raster position
  task automatic pulse_reset(input int n);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      #1;
      check("rst_addr", {13'h0, fb_read_address}, 32'h0);
      check("rst_rgb", {8'h0, R, G, B}, 32'h0);
      check("rst_line_valid", {31'h0, line_valid}, 32'h0);
      check("rst_underflow", {31'h0, underflow}, 32'h0);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    int r;
    Reset = 1'b0;
    DRAWX = '0;
    DRAWY = '0;
    model_reset();
    for (int row = 0; row < 160; row++)
      for (int c = 0; c < 240; c++)
        fb_mem[row * 240 + c] = {8'(row), 8'(c), 8'hA5};
    repeat (3) @(negedge Clk);
    check("reset_rgb", {8'h0, R, G, B}, 32'h0);
    check("reset_underflow", {31'h0, underflow}, 32'h0);
    Reset = 1'b1;

    // First pairs after reset, with row 5 rewritten while row 89 is on screen
    for (int y = 78; y <= 98; y++) run_row(y, (y == 89) ? 5 : -1);

    // Row 99 stuck at DRAWX = 0: no fetch, so rows 100-101 underflow
    repeat (800) step(0, 99);
    for (int y = 100; y <= 104; y++) run_row(y);

    // Bottom of window, last source row, frame wrap
    for (int y = 395; y <= 401; y++) run_row(y);
    run_row(523);
    run_row(524);
    for (int y = 0; y <= 2; y++) run_row(y);

    // Random row pairs with random line contents
    repeat (2) begin
      r = 82 + 2 * int'($urandom_range(0, 158));
      run_row(r - 1, (r - 80) / 2);
      run_row(r);
      run_row(r + 1);
    end

    // Reset in the middle of the row 81 fetch
    run_row(79);
    run_row(80);
    for (int x = 0; x <= 600; x++) step(x, 81);
    pulse_reset(int'($urandom_range(2, 8)));
    for (int x = 601; x < 800; x++) step(x, 81);
    for (int y = 82; y <= 85; y++) run_row(y);
    @(negedge Clk);
    check("final_rgb", {8'h0, R, G, B}, {8'h0, m_rgb});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Read-side scan-out engine for the 240x160 framebuffer RAM. It prefetches one source line per display-line pair into a ping-pong line buffer during the right-hand horizontal tail (DRAWX 560..799). It then drives R/G/B with 2x horizontal and 2x vertical replication into the 480x320 window at (80,80). It replaces direct combinational framebuffer reads on the display path, so display reads no longer depend on the RAM read address being valid in the same cycle.

## Interface
Parameters:
- SRC_W, 240, source pixels per line
- SRC_H, 160, source lines
- X_START, 80, first display column of window
- Y_START, 80, first display row of window
- FETCH_X, 560, DRAWX at which line prefetch starts
- V_TOTAL, 525, display rows per frame

Ports:
- Clk  in  1  VGA pixel clock; all logic on rising edge
- Reset  in  1  asynchronous, active-low reset (Reset = 0 resets)
- DRAWX  in  10  current display column from VGA controller, 0..799
- DRAWY  in  10  current display row, 0..V_TOTAL-1
- fb_read_address  out  19  framebuffer read address
- fb_data  in  24  framebuffer read data, valid 1 Clk after address
- R, G, B  out  8 each  pixel colour, registered
- line_valid  out  1  front buffer holds a fetched line
- underflow  out  1  sticky; a window row pair started with no fetched line

## Operation
- Storage: two 240x24 line buffers, A and B. front_sel selects the display buffer. valid[1:0] holds one flag per buffer.
- Fetch trigger: at DRAWX == FETCH_X on row y, fetch source row s = (y+1-Y_START)/2. Trigger only when y+1 lies in [Y_START, Y_START+2*SRC_H) and (y+1-Y_START) is even; otherwise no fetch on that row.
  - Row y = V_TOTAL-1 wraps to y+1 = 0, which is outside the window, so no fetch occurs there.
- Fetch FSM:
  - IDLE -> FETCH on trigger. Clear col and clear valid[~front_sel].
  - FETCH: fb_read_address = s*SRC_W + col; col increments each Clk.
  - Write pipeline: one Clk later, write fb_data into back[col_d].
  - FETCH -> DRAIN after col = SRC_W-1 is issued.
  - DRAIN: write the last word, set valid[~front_sel] -> IDLE.
- Address in IDLE: fb_read_address holds 0.
- Swap: at DRAWX == 0 on a row with (DRAWY-Y_START) even and in window, front_sel toggles if valid[~front_sel] = 1. Otherwise set underflow and clear line_valid for that row pair.
- Display: if DRAWX in [X_START, X_START+2*SRC_W) and DRAWY in window and line_valid, output front[(DRAWX-X_START)>>1]. Otherwise output R = G = B = 0.
- Odd rows of a pair reuse the same front buffer (vertical replication); no swap occurs on odd rows.
- Arithmetic: s*SRC_W computed in 19 bits; max address 159*240+239 = 38399. Column index is 8 bits.
- FETCH_X + SRC_W + 1 must be <= 801; the final write lands at DRAWX = 0 of the next row, before the swap compare resolves.
  - The swap compare at DRAWX == 0 uses valid[~front_sel] after the DRAIN write. The DRAIN write and its valid-set take priority.
- Reset (any time, including mid-fetch): FSM = IDLE, valid = 00, front_sel = 0, line_valid = 0, underflow = 0, R = G = B = 0, fb_read_address = 0. Line buffer contents are not cleared.

## Timing
- R/G/B lag DRAWX/DRAWY by exactly 1 Clk (registered output).
- Fetch: addresses issued on 240 consecutive Clk starting the cycle DRAWX == FETCH_X is sampled. Data written 1 Clk after each address. valid is set 241 Clk after the trigger.
- Simultaneous trigger and swap cannot occur at default parameters. If a swap and a trigger fall in the same Clk, the swap applies first and the fetch targets the new back buffer.
- DRAWX skipping FETCH_X (e.g. reset release mid-row) means no fetch for that row. The next row pair shows black and asserts underflow.

## Test plan
- Reset mid-fetch: assert Reset at DRAWX = 600, row 81 -> fb_read_address = 0 and valid = 00 while low. After release, rows 82-83 are black and underflow = 1.
- Full frame: FB preloaded with pixel(c,r) = {r[7:0], c[7:0], 8'hA5}, run 2 frames from reset.
  - Display (x,y) in window with 1-Clk lag -> {(y-80)/2, (x-80)/2, A5}.
  - Outside window -> 0.
  - Frame 1, rows 80-81 -> {0,c,A5}.
- Address sequence: on row 79 -> addresses 0..239 at DRAWX 560..799. On row 397 -> 38160..38399. Rows 80, 398, 524 -> no fetch (address stays 0).
- Horizontal replication: row 80, DRAWX 80 and 81 -> both pixel(0,0). DRAWX 558 and 559 -> pixel(239,0). DRAWX 560 -> 0.
- Underflow stickiness: hold DRAWX at 0 for all of row 99 (no fetch) -> rows 100-101 black and underflow = 1. Row 102 onward displays normally; underflow stays 1 until reset.
- Ping-pong integrity: change FB row 5 while row 89 is displaying -> rows 88-89 unchanged; rows 90-91 show the new row 5.
